// File: rtl/bin_to_bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq_if
// Request/result bundle for the sequential binary-to-BCD converter.
//   start   : conversion request (master -> slave)
//   bin_in  : unsigned binary value, captured when start is accepted
//   busy    : conversion in progress (slave -> master)
//   done    : one-cycle pulse, bcd_out newly valid
//   bcd_out : packed BCD result, digit k in [4k+3:4k]
// ---------------------------------------------------------------------------
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential shift-and-add-3 (double dabble) binary-to-BCD converter.
// One conversion takes WIDTH shift cycles plus one DONE cycle; the result
// register only changes when a conversion completes (or on reset).
// Ports:
//   clk   : clock, all registers update on the rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of bin_to_bcd_seq_if (start, bin_in, busy, done,
//           bcd_out)
// The integrator must keep 10^DIGITS > 2^WIDTH - 1 (not checked here).
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    bin_to_bcd_seq_if.slave      bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int TOT_W = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_shift;
    logic [BCD_W-1:0]    r_scratch;
    logic [BCD_W-1:0]    r_bcd;
    logic [CNT_W-1:0]    r_cnt;

    logic [BCD_W-1:0]    w_corrected;
    logic [TOT_W-1:0]    w_shifted;
    logic                w_last;

    // Add-3 correction on every scratch digit in parallel. Digits stay <= 9
    // going in, so a corrected digit is at most 12 and never carries out.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_corrected[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5)
                                          ? r_scratch[4*gi +: 4] + 4'd3
                                          : r_scratch[4*gi +: 4];
        end
    endgenerate

    // Corrected scratch and binary shift register move left as one word; the
    // binary MSB falls into scratch bit 0, the scratch MSB drops off.
    assign w_shifted = {w_corrected, r_shift} << 1;

    assign w_last = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last)    w_state_next = ST_DONE;
            ST_DONE:                 w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_shift   <= bus.bin_in;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= w_shifted[TOT_W-1:WIDTH];
                    r_shift   <= w_shifted[WIDTH-1:0];
                    r_cnt     <= r_cnt + 1'b1;
                    // Publish only the finished value, never a partial one.
                    if (w_last) begin
                        r_bcd <= w_shifted[TOT_W-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (r_state == ST_SHIFT);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.bcd_out = r_bcd;

endmodule
